rr_mux_sel_arbiter: RTL and testbench
=====================================

# rr_mux_sel_arbiter

Four-channel round-robin arbiter that generates the 2-bit select for the 4:1 data multiplexer and registers the chosen word into a single-entry valid/ready output stage. It sits directly upstream of the 4:1 mux. It decides which of inputs a/b/c/d the mux passes each cycle, returns a one-cycle grant to the winning source, and presents the selected data with a channel tag to the consumer. Throughput is one word per cycle; fairness is strict rotation.

## Interface
- DW, 4, data width of each channel and of out_data
- clk  input  1  rising-edge clock
- rstn  input  1  synchronous active-low reset, sampled on rising clk edge
- a, b, c, d  input  DW each  channel 0..3 data, valid while matching req bit is high
- req  input  4  per-channel request; bit i = channel i has a word
- gnt  output  4  one-hot, combinational; bit i high = channel i word consumed this cycle
- sel  output  2  combinational mux select = index of granted channel; 2'b00 when no grant
- out_data  output  DW  registered selected word
- out_sel  output  2  registered channel tag of out_data
- out_valid  output  1  out_data/out_sel hold a word
- out_ready  input  1  consumer accepts word when out_valid && out_ready

## Operation
- Output stage states: EMPTY (out_valid=0), FULL (out_valid=1).
- load_en = !out_valid || out_ready. Arbitration happens only when load_en=1 and req != 0.
- Round-robin pointer ptr[1:0] = last granted channel. Search order ptr+1, ptr+2, ptr+3, ptr (mod 4); the first set req bit wins. The winner becomes the new ptr at the clock edge.
- On a win: gnt[win]=1, sel=win, and on the edge out_data <= selected input, out_sel <= win, out_valid <= 1.
- When load_en=0 or req=0: gnt=0, sel=2'b00, ptr unchanged.
- Transitions:
  - EMPTY -> FULL on a win.
  - FULL -> FULL on out_ready with a win (back-to-back), or on !out_ready (hold; out_data/out_sel stable, no grant).
  - FULL -> EMPTY on out_ready with no win.
- A source whose gnt is low must hold req and data. A source may drop req at any time before it is granted, and dropping produces no grant.
- The output datapath is a pure DW-bit copy with no width conversion. ptr wraps 3 -> 0 naturally.

## Timing
- Reset (rstn=0 at an edge) forces:
  - out_valid=0, out_data=0, out_sel=0, ptr=3 (so channel 0 has first priority).
  - gnt=0 and sel=0 for the whole cycle rstn is low, regardless of req/out_ready.
- Reset mid-operation discards any held word with no completion; the first post-reset grant is the lowest requesting index.
- Latency: a word granted in cycle N appears with out_valid=1 in cycle N+1.
- With out_ready held high and req≠0, one grant and one output word every cycle, with no bubble.
- Backpressure: out_valid && !out_ready freezes all outputs and issues no grant. The cycle out_ready rises, a new grant occurs in the same cycle as the handoff.
- Simultaneous handoff and load in the same cycle are legal. out_valid stays 1 and data is replaced at the edge.
- gnt and sel depend combinationally on req, out_valid, out_ready, ptr and rstn. There is no combinational path from a/b/c/d to any output.

## Test plan
- Reset: hold rstn=0 for 3 cycles with req=4'hF and out_ready=1. Required: gnt=0, sel=0, out_valid=0, out_data=0 throughout. First release cycle: gnt=4'b0001, sel=0.
- Full-load rotation: req=4'hF, a=1, b=2, c=3, d=4, out_ready=1. Required: out_data sequence 1,2,3,4,1 on consecutive cycles, with out_sel 0,1,2,3,0.
- Sparse rotation: req=4'b1010, out_ready=1. Required: grants alternate channel 1, channel 3, channel 1 (out_sel 1,3,1). Channels 0/2 are never granted.
- Backpressure: after one word is loaded (out_data=2, out_sel=1), hold out_ready=0 for 4 cycles with req=4'hF. Required: gnt=0 and out_data=2 steady. On out_ready=1, channel 2 is granted the same cycle and out_data=3 the next cycle.
- Drain: single req pulse on channel 3 (d=4'hA) with out_ready=1. Required: out_valid high for exactly one cycle with out_data=4'hA and out_sel=3, then EMPTY.
- Reset mid-stream: assert rstn=0 while FULL with out_ready=0. Required: out_valid=0 after that edge. After release with req=4'b0110, the first grant is channel 1.

Source files
------------

// File: rtl/rr_mux_sel_arbiter.sv
// Four-channel round-robin arbiter driving a 4:1 mux select,
// with a single-entry registered valid/ready output stage.
module rr_mux_sel_arbiter #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  input  logic [3:0]    req,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_sel,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_ptr;
  logic [DW-1:0] r_data;
  logic [1:0]    r_sel;

  logic          w_load_en;
  logic          w_arb_en;
  logic          w_win_vld;
  logic [1:0]    w_win;
  logic [1:0]    w_idx;
  logic [DW-1:0] w_mux;

  assign w_load_en = (r_state == S_EMPTY) || out_ready;
  // Reset gates arbitration combinationally so no grant leaks out
  // during a cycle whose edge will discard the state anyway.
  assign w_arb_en  = rstn && w_load_en;

  always_comb begin
    w_win_vld = 1'b0;
    w_win     = 2'd0;
    w_idx     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_ptr + k[1:0];
      if (w_arb_en && !w_win_vld && req[w_idx]) begin
        w_win_vld = 1'b1;
        w_win     = w_idx;
      end
    end
  end

  assign gnt = w_win_vld ? (4'b0001 << w_win) : 4'b0000;
  assign sel = w_win_vld ? w_win : 2'b00;

  always_comb begin
    w_mux = a;
    case (w_win)
      2'd0: w_mux = a;
      2'd1: w_mux = b;
      2'd2: w_mux = c;
      2'd3: w_mux = d;
      default: w_mux = a;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_EMPTY: begin
        if (w_win_vld)
          w_state_nxt = S_FULL;
      end
      S_FULL: begin
        if (out_ready && !w_win_vld)
          w_state_nxt = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_EMPTY;
      r_ptr   <= 2'd3;
      r_data  <= '0;
      r_sel   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_win_vld) begin
        r_ptr  <= w_win;
        r_data <= w_mux;
        r_sel  <= w_win;
      end
    end
  end

  assign out_valid = (r_state == S_FULL);
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// Scoreboard bench for rr_mux_sel_arbiter: directed plan
// scenarios followed by protocol-obeying random traffic.
module tb_rr_mux_sel_arbiter;

  localparam int DW = 4;

  logic          clk;
  logic          rstn;
  logic [DW-1:0] a, b, c, d;
  logic [3:0]    req;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] out_data;
  logic [1:0]    out_sel;
  logic          out_valid;
  logic          out_ready;

  rr_mux_sel_arbiter #(.DW(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    tag;
  } item_t;

  item_t         q[$];
  int            errors = 0;
  int            checks = 0;

  logic [DW-1:0] dat [4];
  int            m_ptr;
  bit            m_valid;
  bit            m_known;
  bit            m_post_rst;
  bit            last_win;
  int            last_ch;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0h expected %0h",
               nm, $time, act, exp);
    end
  endtask

  task automatic set_data(input logic [DW-1:0] x0,
                          input logic [DW-1:0] x1,
                          input logic [DW-1:0] x2,
                          input logic [DW-1:0] x3);
    dat[0] = x0;
    dat[1] = x1;
    dat[2] = x2;
    dat[3] = x3;
  endtask

  // One clock cycle: drive, check combinational grant against the
  // model, push any expected output word, advance model state.
  task automatic step(input logic r,
                      input logic [3:0] rq,
                      input logic rdy);
    int     ch;
    bit     win;
    bit     load;
    @(negedge clk);
    rstn      = r;
    req       = rq;
    a         = dat[0];
    b         = dat[1];
    c         = dat[2];
    d         = dat[3];
    out_ready = rdy;
    #1;
    if (m_known)
      chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_post_rst) begin
      chk("rst_data", 32'(out_data), 0);
      chk("rst_sel", 32'(out_sel), 0);
    end
    win = 0;
    ch  = 0;
    if (!r) begin
      chk("gnt_rst", 32'(gnt), 0);
      chk("sel_rst", 32'(sel), 0);
      q.delete();
      m_ptr      = 3;
      m_valid    = 0;
      m_known    = 1;
      m_post_rst = 1;
    end else begin
      m_post_rst = 0;
      load = !m_valid || rdy;
      if (load) begin
        for (int k = 1; k <= 4; k++) begin
          if (!win && rq[(m_ptr + k) % 4]) begin
            win = 1;
            ch  = (m_ptr + k) % 4;
          end
        end
      end
      if (win) begin
        chk("gnt", 32'(gnt), 32'(1 << ch));
        chk("sel", 32'(sel), 32'(ch));
        q.push_back('{data: dat[ch], tag: 2'(ch)});
        m_ptr   = ch;
        m_valid = 1;
      end else begin
        chk("gnt_idle", 32'(gnt), 0);
        chk("sel_idle", 32'(sel), 0);
        if (rdy)
          m_valid = 0;
      end
    end
    last_win = win;
    last_ch  = ch;
  endtask

  // Monitor: compares the presented word against the scoreboard
  // head every valid cycle; pops on a completed handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rstn === 1'b1 && out_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected t=%0t: got valid word %0h expected none",
                   $time, out_data);
        end else begin
          chk("out_data", 32'(out_data), 32'(q[0].data));
          chk("out_sel", 32'(out_sel), 32'(q[0].tag));
          if (out_ready === 1'b1)
            void'(q.pop_front());
        end
      end
    end
  end

  bit            pend [4];
  logic [DW-1:0] pdat [4];
  logic [3:0]    rq;
  logic          rr;

  initial begin
    rstn      = 1'b0;
    req       = 4'h0;
    out_ready = 1'b1;
    m_ptr     = 3;
    m_valid   = 0;
    m_known   = 0;
    set_data(4'd1, 4'd2, 4'd3, 4'd4);
    a = dat[0]; b = dat[1]; c = dat[2]; d = dat[3];

    // Reset held with everything requesting
    repeat (3) step(1'b0, 4'hF, 1'b1);
    // Full-load rotation: 1,2,3,4,1
    repeat (5) step(1'b1, 4'hF, 1'b1);
    // Sparse rotation: 1,3,1
    repeat (3) step(1'b1, 4'b1010, 1'b1);

    // Backpressure with channel 1 word loaded
    step(1'b0, 4'h0, 1'b1);
    step(1'b1, 4'b0010, 1'b1);
    repeat (4) step(1'b1, 4'hF, 1'b0);
    step(1'b1, 4'hF, 1'b1);
    step(1'b1, 4'h0, 1'b1);
    step(1'b1, 4'h0, 1'b1);

    // Drain: single pulse on channel 3
    set_data(4'd1, 4'd2, 4'd3, 4'hA);
    step(1'b1, 4'b1000, 1'b1);
    step(1'b1, 4'h0, 1'b1);
    step(1'b1, 4'h0, 1'b1);

    // Reset while FULL and stalled
    step(1'b1, 4'hF, 1'b1);
    step(1'b1, 4'hF, 1'b0);
    step(1'b0, 4'hF, 1'b0);
    step(1'b1, 4'b0110, 1'b1);
    step(1'b1, 4'h0, 1'b1);

    // Random traffic with sources that hold until granted
    for (int i = 0; i < 4; i++) begin
      pend[i] = 0;
      pdat[i] = '0;
    end
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            pend[i] = 1;
            pdat[i] = DW'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pend[i] = 0;
        end
      end
      rq = {pend[3], pend[2], pend[1], pend[0]};
      rr = ($urandom_range(0, 99) != 0);
      set_data(pdat[0], pdat[1], pdat[2], pdat[3]);
      step(rr, rq, ($urandom_range(0, 3) != 0));
      if (last_win)
        pend[last_ch] = 0;
    end

    step(1'b1, 4'h0, 1'b1);
    step(1'b1, 4'h0, 1'b1);
    @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
